serial_word_rx: RTL and testbench

- Serial-in/parallel-out receiver: the reading end of the team's shift-register serial pattern path.
- Samples a single-bit line on externally supplied sample ticks (e.g. from the pulse generator).
- Frames one start bit, WIDTH data bits and one stop bit, then presents the assembled word with a one-cycle valid strobe.
- Sits between the tick source and the display mux, so a serial stream can be captured and shown as a 16-bit word.

---
 rtl/serial_word_rx.sv | 127 ++++++++++++
 tb/tb_serial_word_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Serial-in/parallel-out receiver. Frames a start bit, WIDTH data bits and a
// stop bit sampled on external ticks, then presents the word with a one-clock
// valid strobe. A low stop bit raises frame_err and waits for the line to idle.
module serial_word_rx #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ser_in,
    output logic [WIDTH-1:0] word_out,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              line;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_in;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

    // State, data path and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic; nothing advances on edges without a tick.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_d      = word_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!line) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], line};
                    end else begin
                        shreg_d = {line, shreg_q[WIDTH-1:1]};
                    end
                    // Counter parks at the last index instead of wrapping.
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (line) begin
                        word_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    // Hold off new starts until the line is seen high.
                    if (line) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs straight from registers / decoded state.
    always_comb begin
        word_out  = word_q;
        valid     = valid_q;
        frame_err = frame_err_q;
        busy      = (state_q == StData) || (state_q == StStop);
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Testbench for serial_word_rx: one MSB-first and one LSB-first instance share
// the same stimulus; outputs are observed on the falling clock edge.
module tb_serial_word_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         ser_in;
    logic [W-1:0] word_m, word_l;
    logic         valid_m, valid_l, err_m, err_l, busy_m, busy_l;

    always #5 clk = ~clk;

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .tick(tick), .ser_in(ser_in),
        .word_out(word_m), .valid(valid_m), .frame_err(err_m), .busy(busy_m)
    );

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .tick(tick), .ser_in(ser_in),
        .word_out(word_l), .valid(valid_l), .frame_err(err_l), .busy(busy_l)
    );

    typedef struct {
        logic [15:0] data;
        logic        stop;
        int          period;
        int          low_ticks;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_msb;
        logic [15:0] exp_lsb;
        int          exp_busy;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int nvalid_m, nvalid_l, nerr_m, nerr_l, busy_ticks, busy_cyc, viol;
    logic pv_m = 1'b0;
    logic pv_l = 1'b0;
    logic [15:0] wq_m[$];
    logic [15:0] wq_l[$];
    int tq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock: observe results of the last edge, then drive the next inputs.
    task automatic step(input logic s, input logic t);
        @(negedge clk);
        cyc++;
        if (valid_m) begin nvalid_m++; wq_m.push_back(word_m); tq.push_back(cyc); end
        if (valid_l) begin nvalid_l++; wq_l.push_back(word_l); end
        if (err_m) nerr_m++;
        if (err_l) nerr_l++;
        if ((valid_m && err_m) || (valid_l && err_l)) viol++;
        if ((valid_m && pv_m) || (valid_l && pv_l)) viol++;
        if (busy_m !== busy_l) viol++;
        pv_m = valid_m;
        pv_l = valid_l;
        if (busy_m) busy_cyc++;
        ser_in = s;
        tick   = t;
        if (t && busy_m) busy_ticks++;
    endtask

    task automatic clear();
        nvalid_m = 0; nvalid_l = 0; nerr_m = 0; nerr_l = 0;
        busy_ticks = 0; busy_cyc = 0;
        wq_m.delete(); wq_l.delete(); tq.delete();
    endtask

    task automatic drive_bit(input logic b, input int period);
        for (int i = 0; i < period; i++) step(b, (i == period - 1));
    endtask

    task automatic idle(input int n, input int period);
        for (int i = 0; i < n; i++) drive_bit(1'b1, period);
    endtask

    // Bits go on the wire data[15] first.
    task automatic send_frame(input logic [15:0] data, input logic stop, input int period);
        drive_bit(1'b0, period);
        for (int i = 15; i >= 0; i--) drive_bit(data[i], period);
        drive_bit(stop, period);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15 - i];
        return r;
    endfunction

    vec_t vecs[5];
    logic [15:0] mdl_m, mdl_l, data;
    logic stop;
    int p, low, gap;

    initial begin
        vecs[0] = '{16'hA5C3, 1'b1, 4, 0, 1, 0, 16'hA5C3, 16'hC3A5, 17};
        vecs[1] = '{16'h8000, 1'b1, 4, 0, 1, 0, 16'h8000, 16'h0001, 17};
        vecs[2] = '{16'h1234, 1'b1, 2, 0, 1, 0, 16'h1234, 16'h2C48, 17};
        vecs[3] = '{16'hFFFF, 1'b0, 4, 3, 0, 1, 16'h1234, 16'h2C48, 17};
        vecs[4] = '{16'h00FF, 1'b1, 4, 0, 1, 0, 16'h00FF, 16'hFF00, 17};
        viol = 0;
        clear();

        // Reset state, with tick high to show it is ignored.
        rst = 1'b1; tick = 1'b1; ser_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset word_msb", word_m, 16'h0);
        check("reset word_lsb", word_l, 16'h0);
        check("reset valid", {valid_m, valid_l}, 2'b00);
        check("reset frame_err", {err_m, err_l}, 2'b00);
        check("reset busy", {busy_m, busy_l}, 2'b00);
        rst = 1'b0; tick = 1'b0;
        idle(4, 4);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            clear();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].period);
            for (int k = 0; k < vecs[v].low_ticks; k++) drive_bit(1'b0, vecs[v].period);
            idle(3, vecs[v].period);
            check($sformatf("vec%0d valid count", v), nvalid_m, vecs[v].exp_valid);
            check($sformatf("vec%0d valid count lsb", v), nvalid_l, vecs[v].exp_valid);
            check($sformatf("vec%0d frame_err count", v), nerr_m + nerr_l, 2 * vecs[v].exp_err);
            check($sformatf("vec%0d word_msb", v), word_m, vecs[v].exp_msb);
            check($sformatf("vec%0d word_lsb", v), word_l, vecs[v].exp_lsb);
            check($sformatf("vec%0d busy ticks", v), busy_ticks, vecs[v].exp_busy);
        end

        // Tick held high, two frames back to back.
        clear();
        send_frame(16'hFFFF, 1'b1, 1);
        send_frame(16'h0000, 1'b1, 1);
        idle(3, 1);
        check("b2b valid count", nvalid_m, 2);
        if (nvalid_m == 2) begin
            check("b2b first word", wq_m[0], 16'hFFFF);
            check("b2b second word", wq_m[1], 16'h0000);
            check("b2b valid spacing", tq[1] - tq[0], 18);
        end
        check("b2b busy ticks", busy_ticks, 34);

        // Reset after the 8th data bit of 0xBEEF.
        clear();
        drive_bit(1'b0, 4);
        for (int i = 15; i >= 8; i--) drive_bit(data_beef(i), 4);
        @(negedge clk);
        rst = 1'b1; tick = 1'b1;
        #1;
        check("midreset word_msb", word_m, 16'h0);
        check("midreset word_lsb", word_l, 16'h0);
        check("midreset busy", busy_m, 1'b0);
        check("midreset valid", valid_m, 1'b0);
        @(negedge clk);
        rst = 1'b0; tick = 1'b0; ser_in = 1'b1;
        pv_m = 1'b0; pv_l = 1'b0;
        idle(3, 4);
        send_frame(16'hBEEF, 1'b1, 4);
        idle(3, 4);
        check("after reset valid count", nvalid_m, 1);
        check("after reset frame_err count", nerr_m, 0);
        check("after reset word_msb", word_m, 16'hBEEF);
        check("after reset word_lsb", word_l, 16'hF77D);

        // Idle line with one-clock low glitches well away from the ticks.
        clear();
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
        idle(2, 4);
        check("glitch busy cycles", busy_cyc, 0);
        check("glitch valid count", nvalid_m + nvalid_l, 0);
        check("glitch frame_err count", nerr_m + nerr_l, 0);
        check("glitch word held", word_m, 16'hBEEF);

        // Random frames against a frame-level reference.
        mdl_m = 16'hBEEF;
        mdl_l = rev16(16'hBEEF);
        for (int f = 0; f < 40; f++) begin
            data = 16'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            p    = $urandom_range(1, 4);
            low  = stop ? 0 : $urandom_range(0, 3);
            gap  = $urandom_range(3, 5);
            clear();
            send_frame(data, stop, p);
            for (int k = 0; k < low; k++) drive_bit(1'b0, p);
            idle(gap, p);
            if (stop) begin
                mdl_m = data;
                mdl_l = rev16(data);
            end
            check($sformatf("rand%0d valid", f), nvalid_m + nvalid_l, stop ? 2 : 0);
            check($sformatf("rand%0d frame_err", f), nerr_m + nerr_l, stop ? 0 : 2);
            check($sformatf("rand%0d word_msb", f), word_m, mdl_m);
            check($sformatf("rand%0d word_lsb", f), word_l, mdl_l);
            check($sformatf("rand%0d busy ticks", f), busy_ticks, 17);
        end

        check("strobe invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic data_beef(input int i);
        logic [15:0] w;
        w = 16'hBEEF;
        return w[i];
    endfunction

    // Safety net against a stuck simulation.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

endmodule
